// File: rtl/move_judge.sv
// move_judge: decides whether a one-step player move is allowed by reading
// the target tile (and, for portals, the destination tile) from map memory.
// Responses are single-cycle accept/deny pulses; all outputs are registered.
module move_judge #(
    parameter logic [18:0] MAP_BASE = 19'd0,
    parameter logic [3:0]  GRID_MAX = 4'd15
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [3:0]  player_x,
    input  logic [3:0]  player_y,
    input  logic        ask_move,
    input  logic [3:0]  ask_x,
    input  logic [3:0]  ask_y,
    output logic [18:0] map_addr,
    input  logic [15:0] map_data,
    output logic        accept_move,
    output logic [3:0]  goto_x,
    output logic [3:0]  goto_y,
    output logic        deny_move,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_TGT  = 2'd1,
        RD_PORT = 2'd2,
        RESP    = 2'd3
    } state_t;

    localparam logic [3:0] TILE_FLOOR  = 4'd0;
    localparam logic [3:0] TILE_PORTAL = 4'd2;

    state_t      state_q, state_d;
    logic [3:0]  tgt_x_q, tgt_x_d;
    logic [3:0]  tgt_y_q, tgt_y_d;
    logic [18:0] map_addr_q, map_addr_d;
    logic        accept_q, accept_d;
    logic        deny_q, deny_d;
    logic        busy_q, busy_d;
    logic [3:0]  goto_x_q, goto_x_d;
    logic [3:0]  goto_y_q, goto_y_d;

    logic [3:0]  tile_type_s;
    logic [3:0]  port_x_s;
    logic [3:0]  port_y_s;
    logic        ask_legal_s;
    logic        port_in_range_s;
    logic        unused_map_bits_s;

    // Word address of tile (x,y); the sum wraps naturally at 19 bits.
    function automatic logic [18:0] tile_addr(input logic [3:0] x, input logic [3:0] y);
        return MAP_BASE + {11'd0, y, x};
    endfunction

    // Absolute difference of two coordinates as a 5-bit unsigned value.
    function automatic logic [4:0] abs_diff(input logic [3:0] a, input logic [3:0] b);
        logic [4:0] r;
        if (a >= b) begin
            r = {1'b0, a} - {1'b0, b};
        end else begin
            r = {1'b0, b} - {1'b0, a};
        end
        return r;
    endfunction

    assign tile_type_s       = map_data[15:12];
    assign port_x_s          = map_data[7:4];
    assign port_y_s          = map_data[3:0];
    assign unused_map_bits_s = ^map_data[11:8];

    // A request is legal when the target is on the grid and exactly one step away.
    always_comb begin
        ask_legal_s = (ask_x <= GRID_MAX) && (ask_y <= GRID_MAX) &&
                      ((abs_diff(ask_x, player_x) + abs_diff(ask_y, player_y)) == 5'd1);
        port_in_range_s = (port_x_s <= GRID_MAX) && (port_y_s <= GRID_MAX);
    end

    // Next-state and registered-output decisions for the judging sequence.
    always_comb begin
        state_d    = state_q;
        tgt_x_d    = tgt_x_q;
        tgt_y_d    = tgt_y_q;
        map_addr_d = map_addr_q;
        accept_d   = 1'b0;
        deny_d     = 1'b0;
        goto_x_d   = goto_x_q;
        goto_y_d   = goto_y_q;

        case (state_q)
            IDLE: begin
                if (ask_move) begin
                    if (ask_legal_s) begin
                        tgt_x_d    = ask_x;
                        tgt_y_d    = ask_y;
                        map_addr_d = tile_addr(ask_x, ask_y);
                        state_d    = RD_TGT;
                    end else begin
                        // Refused without touching memory; no RESP visit needed.
                        deny_d = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RD_TGT: begin
                case (tile_type_s)
                    TILE_FLOOR: begin
                        accept_d = 1'b1;
                        goto_x_d = tgt_x_q;
                        goto_y_d = tgt_y_q;
                        state_d  = RESP;
                    end
                    TILE_PORTAL: begin
                        if (port_in_range_s) begin
                            // Reuse the target registers to hold the portal exit.
                            tgt_x_d    = port_x_s;
                            tgt_y_d    = port_y_s;
                            map_addr_d = tile_addr(port_x_s, port_y_s);
                            state_d    = RD_PORT;
                        end else begin
                            deny_d  = 1'b1;
                            state_d = RESP;
                        end
                    end
                    default: begin
                        // Walls and every unknown type block the move.
                        deny_d  = 1'b1;
                        state_d = RESP;
                    end
                endcase
            end
            RD_PORT: begin
                // Only a floor exit is usable; portals do not chain.
                if (tile_type_s == TILE_FLOOR) begin
                    accept_d = 1'b1;
                    goto_x_d = tgt_x_q;
                    goto_y_d = tgt_y_q;
                end else begin
                    deny_d = 1'b1;
                end
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset aborts any request in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            tgt_x_q    <= 4'd0;
            tgt_y_q    <= 4'd0;
            map_addr_q <= MAP_BASE;
            accept_q   <= 1'b0;
            deny_q     <= 1'b0;
            busy_q     <= 1'b0;
            goto_x_q   <= 4'd0;
            goto_y_q   <= 4'd0;
        end else begin
            state_q    <= state_d;
            tgt_x_q    <= tgt_x_d;
            tgt_y_q    <= tgt_y_d;
            map_addr_q <= map_addr_d;
            accept_q   <= accept_d;
            deny_q     <= deny_d;
            busy_q     <= busy_d;
            goto_x_q   <= goto_x_d;
            goto_y_q   <= goto_y_d;
        end
    end

    assign map_addr    = map_addr_q;
    assign accept_move = accept_q;
    assign deny_move   = deny_q;
    assign busy        = busy_q;
    assign goto_x      = goto_x_q;
    assign goto_y      = goto_y_q;

endmodule

// File: tb/tb_move_judge.sv
// Bench for move_judge: directed table, hand-written multi-cycle sequences,
// and random requests checked against a rule-level model of the judge.
module tb_move_judge;

    localparam logic [18:0] TB_BASE = 19'h7FFF0;
    localparam logic [3:0]  TB_GMAX = 4'd13;

    logic        clk;
    logic        rstn;
    logic [3:0]  player_x, player_y, ask_x, ask_y;
    logic        ask_move;
    logic [18:0] map_addr;
    logic [15:0] map_data;
    logic        accept_move, deny_move, busy;
    logic [3:0]  goto_x, goto_y;

    logic [15:0] mem [256];
    logic [18:0] off_s;

    int total = 0;
    int bad   = 0;

    // Observations of one request
    int          o_lat, o_np;
    bit          o_acc, o_both, o_busy1, o_busy_end;
    logic [18:0] o_a0, o_a1;
    logic [3:0]  o_gx, o_gy;

    // Model state
    logic [3:0]  m_gx, m_gy;
    logic [18:0] m_addr;

    move_judge #(.MAP_BASE(TB_BASE), .GRID_MAX(TB_GMAX)) dut (
        .clk(clk), .rstn(rstn),
        .player_x(player_x), .player_y(player_y),
        .ask_move(ask_move), .ask_x(ask_x), .ask_y(ask_y),
        .map_addr(map_addr), .map_data(map_data),
        .accept_move(accept_move), .goto_x(goto_x), .goto_y(goto_y),
        .deny_move(deny_move), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory answers combinationally from the registered address.
    assign off_s    = map_addr - TB_BASE;
    assign map_data = mem[off_s[7:0]];

    typedef struct {
        logic [3:0]  px, py, ax, ay;
        logic [15:0] tt, td;
        int          lat;
        bit          acc;
        logic [3:0]  gx, gy;
    } vec_t;

    vec_t tbl [12];

    function automatic logic [18:0] addr_of(input int x, input int y);
        return TB_BASE + 19'(y * 16 + x);
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fill_mem(input logic [15:0] v);
        for (int i = 0; i < 256; i++) mem[i] = v;
    endtask

    // Sample outputs for six cycles starting #1 after the request edge.
    task automatic observe();
        o_lat = 0; o_np = 0; o_acc = 0; o_both = 0; o_busy1 = 0;
        ask_move = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            if (accept_move && deny_move) o_both = 1;
            if (accept_move || deny_move) begin
                o_np++;
                if (o_lat == 0) begin
                    o_lat = k;
                    o_acc = accept_move;
                end
            end
            if (k == 1) begin
                o_a0    = map_addr;
                o_busy1 = busy;
            end
            if (k == 2) o_a1 = map_addr;
            if (k < 6) begin
                @(posedge clk);
                #1;
            end
        end
        o_gx = goto_x;
        o_gy = goto_y;
        o_busy_end = busy;
    endtask

    task automatic run_req(input logic [3:0] px, input logic [3:0] py,
                           input logic [3:0] ax, input logic [3:0] ay);
        @(negedge clk);
        player_x = px; player_y = py; ask_x = ax; ask_y = ay;
        ask_move = 1'b1;
        @(posedge clk);
        #1;
        observe();
    endtask

    task automatic expect_req(input string nm, input int lat, input bit acc,
                              input logic [3:0] gx, input logic [3:0] gy,
                              input logic [18:0] a0, input logic [18:0] a1);
        chk({nm, " latency"}, o_lat, lat);
        chk({nm, " accept"}, {31'd0, o_acc}, {31'd0, acc});
        chk({nm, " pulses"}, o_np, 1);
        chk({nm, " both"}, {31'd0, o_both}, 32'd0);
        chk({nm, " goto"}, {24'd0, o_gx, o_gy}, {24'd0, gx, gy});
        chk({nm, " addr0"}, {13'd0, o_a0}, {13'd0, a0});
        chk({nm, " addr1"}, {13'd0, o_a1}, {13'd0, a1});
        if (lat > 1) chk({nm, " busy"}, {31'd0, o_busy1}, 32'd1);
        chk({nm, " idle"}, {31'd0, o_busy_end}, 32'd0);
    endtask

    // Rule-level model: legality, tile classes, one portal hop.
    task automatic model(input int px, input int py, input int ax, input int ay,
                         output int lat, output bit acc,
                         output logic [18:0] a0, output logic [18:0] a1);
        int g, t, ty, dx, dy, d;
        g = int'(TB_GMAX);
        acc = 0;
        a0 = m_addr;
        a1 = m_addr;
        if (ax > g || ay > g || (iabs(ax - px) + iabs(ay - py)) != 1) begin
            lat = 1;
        end else begin
            a0 = addr_of(ax, ay);
            a1 = a0;
            t  = int'(mem[ay * 16 + ax]);
            ty = t / 4096;
            lat = 2;
            if (ty == 0) begin
                acc = 1; m_gx = 4'(ax); m_gy = 4'(ay);
            end else if (ty == 2) begin
                dx = (t / 16) % 16;
                dy = t % 16;
                if (dx <= g && dy <= g) begin
                    lat = 3;
                    a1 = addr_of(dx, dy);
                    d = int'(mem[dy * 16 + dx]);
                    if (d / 4096 == 0) begin
                        acc = 1; m_gx = 4'(dx); m_gy = 4'(dy);
                    end
                end
            end
        end
        m_addr = a1;
    endtask

    initial begin
        int lat;
        bit acc;
        logic [18:0] a0, a1;
        logic [15:0] tt;

        //          px    py    ax    ay    target    dest     lat acc gx     gy
        tbl[0]  = '{4'd3, 4'd3, 4'd4, 4'd3, 16'h0000, 16'h0000, 2, 1, 4'd4,  4'd3};
        tbl[1]  = '{4'd3, 4'd3, 4'd3, 4'd2, 16'h1000, 16'h0000, 2, 0, 4'd4,  4'd3};
        tbl[2]  = '{4'd3, 4'd3, 4'd5, 4'd3, 16'h0000, 16'h0000, 1, 0, 4'd4,  4'd3};
        tbl[3]  = '{4'd3, 4'd3, 4'd3, 4'd3, 16'h0000, 16'h0000, 1, 0, 4'd4,  4'd3};
        tbl[4]  = '{4'd0, 4'd0, 4'd1, 4'd0, 16'h2089, 16'h0000, 3, 1, 4'd8,  4'd9};
        tbl[5]  = '{4'd0, 4'd0, 4'd1, 4'd0, 16'h2089, 16'h1000, 3, 0, 4'd8,  4'd9};
        tbl[6]  = '{4'd0, 4'd0, 4'd0, 4'd1, 16'h20E1, 16'h0000, 2, 0, 4'd8,  4'd9};
        tbl[7]  = '{4'd13, 4'd5, 4'd14, 4'd5, 16'h0000, 16'h0000, 1, 0, 4'd8, 4'd9};
        tbl[8]  = '{4'd5, 4'd5, 4'd5, 4'd6, 16'h5000, 16'h0000, 2, 0, 4'd8,  4'd9};
        tbl[9]  = '{4'd2, 4'd2, 4'd1, 4'd2, 16'h2033, 16'h2011, 3, 0, 4'd8,  4'd9};
        tbl[10] = '{4'd13, 4'd13, 4'd13, 4'd12, 16'h0ABC, 16'h0000, 2, 1, 4'd13, 4'd12};
        tbl[11] = '{4'd6, 4'd6, 4'd6, 4'd7, 16'h2A23, 16'h0FFF, 3, 1, 4'd2,  4'd3};

        rstn = 1'b0; ask_move = 1'b0;
        player_x = 4'd0; player_y = 4'd0; ask_x = 4'd0; ask_y = 4'd0;
        fill_mem(16'h1000);
        m_gx = 4'd0; m_gy = 4'd0; m_addr = TB_BASE;

        // First request lands in the very first cycle out of reset.
        mem[3 * 16 + 4] = 16'h0000;
        #12;
        chk("reset accept", {31'd0, accept_move}, 32'd0);
        chk("reset deny", {31'd0, deny_move}, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset goto", {24'd0, goto_x, goto_y}, 32'd0);
        chk("reset addr", {13'd0, map_addr}, {13'd0, TB_BASE});
        player_x = 4'd3; player_y = 4'd3; ask_x = 4'd4; ask_y = 4'd3; ask_move = 1'b1;
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        observe();
        model(3, 3, 4, 3, lat, acc, a0, a1);
        expect_req("first cycle", lat, acc, m_gx, m_gy, a0, a1);

        // Directed table.
        for (int i = 0; i < 12; i++) begin
            fill_mem(16'h1000);
            tt = tbl[i].tt;
            mem[int'(tbl[i].ay) * 16 + int'(tbl[i].ax)] = tt;
            if (tt[15:12] == 4'd2 && tt[7:4] <= TB_GMAX && tt[3:0] <= TB_GMAX)
                mem[int'(tt[3:0]) * 16 + int'(tt[7:4])] = tbl[i].td;
            run_req(tbl[i].px, tbl[i].py, tbl[i].ax, tbl[i].ay);
            a0 = (tbl[i].lat == 1) ? m_addr : addr_of(int'(tbl[i].ax), int'(tbl[i].ay));
            a1 = (tbl[i].lat == 3) ? addr_of(int'(tt[7:4]), int'(tt[3:0])) : a0;
            m_addr = a1;
            m_gx = tbl[i].gx; m_gy = tbl[i].gy;
            expect_req($sformatf("vec%0d", i), tbl[i].lat, tbl[i].acc,
                       tbl[i].gx, tbl[i].gy, a0, a1);
        end

        // Second ask one cycle after the first is ignored.
        fill_mem(16'h1000);
        mem[3 * 16 + 4] = 16'h0000;
        mem[3 * 16 + 2] = 16'h0000;
        @(negedge clk);
        player_x = 4'd3; player_y = 4'd3; ask_x = 4'd4; ask_y = 4'd3; ask_move = 1'b1;
        @(posedge clk);
        #1;
        ask_x = 4'd2;
        @(posedge clk);
        #1;
        observe();
        chk("b2b pulses", o_np, 1);
        chk("b2b accept", {31'd0, o_acc}, 32'd1);
        chk("b2b latency", o_lat, 1);
        chk("b2b goto", {24'd0, o_gx, o_gy}, {24'd0, 4'd4, 4'd3});
        m_gx = 4'd4; m_gy = 4'd3; m_addr = addr_of(4, 3);

        // Reset pulse while reading the portal exit aborts silently.
        fill_mem(16'h1000);
        mem[1] = 16'h2089;
        mem[9 * 16 + 8] = 16'h0000;
        @(negedge clk);
        player_x = 4'd0; player_y = 4'd0; ask_x = 4'd1; ask_y = 4'd0; ask_move = 1'b1;
        @(posedge clk);
        #1;
        ask_move = 1'b0;
        @(posedge clk);
        #1;
        chk("abort in portal read", {13'd0, map_addr}, {13'd0, addr_of(8, 9)});
        rstn = 1'b0;
        #1;
        chk("abort accept", {31'd0, accept_move}, 32'd0);
        chk("abort deny", {31'd0, deny_move}, 32'd0);
        chk("abort busy", {31'd0, busy}, 32'd0);
        chk("abort goto", {24'd0, goto_x, goto_y}, 32'd0);
        chk("abort addr", {13'd0, map_addr}, {13'd0, TB_BASE});
        @(negedge clk);
        rstn = 1'b1;
        o_np = 0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            if (accept_move || deny_move) o_np++;
        end
        chk("abort no pulse", o_np, 0);
        m_gx = 4'd0; m_gy = 4'd0; m_addr = TB_BASE;
        run_req(4'd0, 4'd0, 4'd1, 4'd0);
        model(0, 0, 1, 0, lat, acc, a0, a1);
        expect_req("after abort", lat, acc, m_gx, m_gy, a0, a1);

        // Random requests against the model.
        for (int it = 0; it < 150; it++) begin
            int px, py, ax, ay, r;
            if (it % 10 == 0) begin
                for (int i = 0; i < 256; i++) begin
                    r = int'($urandom_range(0, 9));
                    tt = 16'($urandom);
                    if (r < 4)       tt[15:12] = 4'd0;
                    else if (r < 6)  tt[15:12] = 4'd1;
                    else if (r < 9)  tt[15:12] = 4'd2;
                    else             tt[15:12] = 4'($urandom_range(3, 15));
                    mem[i] = tt;
                end
            end
            px = int'($urandom_range(0, 15));
            py = int'($urandom_range(0, 15));
            r  = int'($urandom_range(0, 9));
            ax = px; ay = py;
            if (r < 7) begin
                case (r % 4)
                    0: ax = (px + 1) % 16;
                    1: ax = (px + 15) % 16;
                    2: ay = (py + 1) % 16;
                    default: ay = (py + 15) % 16;
                endcase
            end else begin
                ax = int'($urandom_range(0, 15));
                ay = int'($urandom_range(0, 15));
            end
            run_req(4'(px), 4'(py), 4'(ax), 4'(ay));
            model(px, py, ax, ay, lat, acc, a0, a1);
            expect_req($sformatf("rand%0d", it), lat, acc, m_gx, m_gy, a0, a1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
